// File: rtl/alu_pkg.sv
// Shared EX-stage encodings: ALU controls, ALUop, M-extension funct3/funct7,
// and the multiply/divide sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } mdu_state_t;

  function automatic logic a_is_signed(
    input logic [2:0] f3
  );
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV)  || (f3 == F3_REM);
  endfunction

  function automatic logic b_is_signed(
    input logic [2:0] f3
  );
    return (f3 == F3_MULH) || (f3 == F3_DIV) ||
           (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX <-> multiply/divide unit request/response bundle.
// master = EX side, slave = sequencer.
interface mdu_sequencer_if #(
  parameter int XLEN = 64
);

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;

  modport master (
    output req_valid,
    output funct3,
    output rs1,
    output rs2,
    output flush,
    input  req_ready,
    input  busy,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  funct3,
    input  rs1,
    input  rs2,
    input  flush,
    output req_ready,
    output busy,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/mdu_shift_core.sv
// Iterative datapath: shift-add multiply / restoring divide on
// unsigned magnitudes, one bit per step. {hi,lo} is the 2*XLEN result.
module mdu_shift_core #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            op_is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] b_q;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  assign sum    = {1'b0, hi} + {1'b0, b_q};
  assign rem_sh = {hi, lo[XLEN-1]};
  assign ge     = rem_sh >= {1'b0, b_q};
  // partial remainder stays below the divisor, so XLEN bits suffice
  assign diff   = rem_sh[XLEN-1:0] - b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi  <= '0;
      lo  <= '0;
      b_q <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= a;
      b_q <= b;
    end else if (step) begin
      if (op_is_div) begin
        if (ge) begin
          hi <= diff;
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= rem_sh[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else if (lo[0]) begin
        hi <= sum[XLEN:1];
        lo <= {sum[0], lo[XLEN-1:1]};
      end else begin
        hi <= {1'b0, hi[XLEN-1:1]};
        lo <= {hi[0], lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV64 M-extension multi-cycle sequencer: FSM, counter, signs, special cases.
// Optional MDU_EARLY_OUT_EN: zero-operand multiplies finish straight from PREP.
module mdu_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic           clk,
  input  logic           reset,
  mdu_sequencer_if.slave io
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MINV = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t state_q, state_d;

  logic [2:0]       f3_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  resp_q;

  logic            accept;
  logic            is_div;
  logic            sa, sb;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div0, ovf, early, special;
  logic [XLEN-1:0] spec_res;
  logic [XLEN-1:0] hi, lo;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo_s, rem_s;
  logic [XLEN-1:0] res_d;

  assign accept = io.req_valid & (state_q == IDLE) & ~io.flush;
  assign is_div = f3_q[2];

  assign sa    = a_is_signed(f3_q) & a_q[XLEN-1];
  assign sb    = b_is_signed(f3_q) & b_q[XLEN-1];
  assign a_abs = sa ? -a_q : a_q;
  assign b_abs = sb ? -b_q : b_q;

  assign div0 = is_div & (b_q == '0);
  assign ovf  = ((f3_q == F3_DIV) || (f3_q == F3_REM)) &
                (a_q == MINV) & (b_q == '1);

`ifdef MDU_EARLY_OUT_EN
  assign early = ~is_div & ((a_q == '0) | (b_q == '0));
`else
  assign early = 1'b0;
`endif

  assign special = div0 | ovf | early;

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      div0:    spec_res = f3_q[1] ? a_q : '1;
      ovf:     spec_res = f3_q[1] ? '0 : a_q;
      default: spec_res = '0;
    endcase
  end

  mdu_shift_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == PREP),
    .step     (state_q == RUN),
    .op_is_div(is_div),
    .a        (a_abs),
    .b        (b_abs),
    .hi       (hi),
    .lo       (lo)
  );

  assign prod_s = (sa ^ sb) ? -{hi, lo} : {hi, lo};
  assign quo_s  = (sa ^ sb) ? -lo : lo;
  assign rem_s  = sa ? -hi : hi;

  always_comb begin
    res_d = '0;
    unique case (1'b1)
      is_div & ~f3_q[1]: res_d = quo_s;
      is_div &  f3_q[1]: res_d = rem_s;
      f3_q == F3_MUL:    res_d = prod_s[XLEN-1:0];
      default:           res_d = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    // flush also beats a request arriving in IDLE
    if (io.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (io.req_valid) state_d = PREP;
        PREP:    state_d = special ? DONE : RUN;
        RUN:     if (cnt_q == LAST) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      resp_q <= '0;
    end else begin
      if (accept) begin
        f3_q <= io.funct3;
        a_q  <= io.rs1;
        b_q  <= io.rs2;
      end
      if (io.flush || state_q != RUN) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
      if (!io.flush && state_q == PREP && special) begin
        resp_q <= spec_res;
      end
      if (!io.flush && state_q == FIX) begin
        resp_q <= res_d;
      end
    end
  end

  assign io.req_ready  = (state_q == IDLE);
  assign io.busy       = (state_q != IDLE) && (state_q != DONE);
  assign io.resp_valid = (state_q == DONE) && !io.flush;
  assign io.resp_data  = resp_q;

endmodule
